sobel_window_gen: RTL and testbench
===================================

// Module: sobel_window_gen
// PURPOSE
//  Producer side of the 3x3 Sobel kernel interface.
//  Accepts the raster RGB444 pixel stream from the camera capture path and buffers two lines.
//  Presents the 8-neighbour 3x3 window (plus centre) with a valid strobe and centre coordinates.
//  Sits between the capture/frame-buffer reader and the combinational Sobel3x3 kernel.
// PARAMETERS
//  IMG_WIDTH   320  active pixels per line (>=3)
//  IMG_HEIGHT  240  active lines per frame (>=3)
//  X_W         9    width of column counters/coords (>= clog2(IMG_WIDTH))
//  Y_W         8    width of row counters/coords (>= clog2(IMG_HEIGHT))
// PORTS
//  clk          in   1     pixel clock; single clock domain
//  rst          in   1     synchronous, active-high reset
//  pix_valid    in   1     pix_data accepted this cycle; gaps allowed anywhere, no backpressure
//  pix_data     in   12    RGB444 {R[11:8],G[7:4],B[3:0]}
//  frame_start  in   1     qualified by pix_valid; marks pixel (0,0) of a frame
//  win_valid    out  1     window outputs valid this cycle
//  win_lu..rd   out  12x9  lu,lm,ld,mu,mm,md,ru,rm,rd (l/m/r = column x-1/x/x+1, u/m/d = row y-1/y/y+1)
//  win_x        out  X_W   centre column, 1..IMG_WIDTH-2
//  win_y        out  Y_W   centre row, 1..IMG_HEIGHT-2
//  frame_done   out  1     1-cycle pulse with the last window of a frame
// BEHAVIOUR
//  Reset: win_valid=0, frame_done=0, all win_* = 0, win_x=win_y=0.
//   FSM -> IDLE; x,y counters = 0.
//  FSM states:
//   IDLE: pixels ignored until pix_valid&frame_start -> ACTIVE.
//   ACTIVE: last pixel (W-1,H-1) accepted -> DONE.
//   DONE: pixels ignored; pix_valid&frame_start -> ACTIVE.
//  Counters: the frame_start pixel is (0,0). Each later accepted pixel does x++.
//   x==IMG_WIDTH-1 wraps to x=0, y++.
//  frame_start in any state (including mid-frame ACTIVE) restarts at (0,0).
//   No flush needed: stale line-buffer rows are never emitted.
//  Window: two line buffers, depth IMG_WIDTH x 12.
//   Pixel at x is written to LB0 at x; the old LB0[x] moves to LB1[x] (read-before-write).
//   Column {LB1,LB0,pix} = {u,m,d} shifts into a 3x3 register array; the l column is the oldest.
//  Output rule: accepted pixel (x,y) with x>=2 and y>=2 produces exactly one window.
//   Centre (x-1,y-1). win_valid is asserted 2 cycles after acceptance (fixed latency, independent of gaps).
//  Border centres (row/col 0 or last) are never emitted; downstream paints them black.
//   Windows per frame = (W-2)*(H-2).
//  No window straddles lines: columns from the previous line are not used while x<2.
//  pix_valid low: no state advance; win_valid=0 two cycles later. win_* hold their last value.
//  frame_done: asserted with the window for centre (W-2,H-2).
//  rst mid-frame: outputs cleared on the next edge; the in-flight pipeline is dropped; FSM returns to IDLE.
// STRUCTURE
//  sobel_pkg:
//   PIX_W=12, typedef pixel_t [11:0]
//   window struct/array type (9 pixel_t), shared with the Sobel3x3 wrapper
//   FSM state enum {IDLE,ACTIVE,DONE}
//  Sub-module line_buffer (DEPTH, PIX_W):
//   single-port, synchronous read, read-before-write, 1-cycle read latency.
//   Instantiated twice; infers BRAM.
//  Top holds: FSM, x/y counters, pixel/coordinate delay pipe aligning with LB read latency,
//   3x3 shift array, output registers.
// TESTING (IMG_WIDTH=8, IMG_HEIGHT=6; pixel = {y[3:0],x[3:0],4'h0} unless noted)
//  1. Full frame, pix_valid held high:
//     -> exactly 24 win_valid pulses, centres raster (1,1)..(6,4).
//     -> first window lu=0x000, mm=0x110, rd=0x220; 2 cycles after pixel (2,2).
//  2. Random pix_valid gaps (~50%):
//     -> identical window sequence to test 1, every window 2 cycles after its completing pixel.
//     -> frame_done coincides with centre (6,4) only.
//  3. Pixels sent before any frame_start -> no win_valid. Then a clean frame -> 24 windows, correct data.
//  4. frame_start asserted at pixel (3,4) of frame A, then frame B (pixel value +0x008):
//     -> no window mixes A/B rows. B yields 24 correct windows.
//  5. rst pulsed at pixel (5,3): next cycle all outputs 0, FSM IDLE.
//     -> remaining pixels ignored; next frame correct.
//  6. Extra pixels after (7,5) without frame_start -> ignored (DONE); no extra win_valid.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types for the 3x3 Sobel window producer and the Sobel3x3 kernel wrapper.
package sobel_pkg;

    localparam int PIX_W = 12;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef struct packed {
        pixel_t lu, lm, ld;
        pixel_t mu, mm, md;
        pixel_t ru, rm, rd;
    } window_t;

    typedef struct packed {
        pixel_t u, m, d;
    } column_t;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

endpackage

// File: rtl/line_buffer.sv
// Single-port line store with synchronous read-before-write and one cycle of read latency.
module line_buffer #(
    parameter int DEPTH = 320,
    parameter int PIX_W = 12,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [PIX_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q    <= mem[addr];
            mem[addr]  <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sobel_window_gen.sv
// Buffers two lines of the raster pixel stream and emits interior 3x3 windows
// with their centre coordinates, two cycles after the completing pixel.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int X_W        = 9,
    parameter int Y_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             frame_start,
    output logic             win_valid,
    output logic [PIX_W-1:0] win_lu,
    output logic [PIX_W-1:0] win_lm,
    output logic [PIX_W-1:0] win_ld,
    output logic [PIX_W-1:0] win_mu,
    output logic [PIX_W-1:0] win_mm,
    output logic [PIX_W-1:0] win_md,
    output logic [PIX_W-1:0] win_ru,
    output logic [PIX_W-1:0] win_rm,
    output logic [PIX_W-1:0] win_rd,
    output logic [X_W-1:0]   win_x,
    output logic [Y_W-1:0]   win_y,
    output logic             frame_done
);

    localparam int LB_AW = $clog2(IMG_WIDTH);
    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

    typedef struct packed {
        logic           acc;
        logic           emit;
        logic           last;
        logic [X_W-1:0] col;
        logic [Y_W-1:0] row;
        pixel_t         pix;
    } stage_t;

    state_t          state_q, state_d;
    logic [X_W-1:0]  x_q, x_d, cur_x;
    logic [Y_W-1:0]  y_q, y_d, cur_y;
    logic            accept, emit, last_pix;

    stage_t          s1_q, s1_d, s2_q, s2_d;
    pixel_t          mid_q, mid_d;
    pixel_t          lb0_rdata, lb1_rdata;
    column_t         new_col;
    column_t         col_l_q, col_l_d, col_m_q, col_m_d;
    window_t         win_q, win_d;
    logic [X_W-1:0]  win_x_q, win_x_d;
    logic [Y_W-1:0]  win_y_q, win_y_d;
    logic            win_valid_q, win_valid_d;
    logic            frame_done_q, frame_done_d;

    // frame_start forces the current pixel to (0,0) from any state
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        cur_x    = frame_start ? '0 : x_q;
        cur_y    = frame_start ? '0 : y_q;
        accept   = pix_valid && (frame_start || state_q == ACTIVE);
        last_pix = (cur_x == X_LAST) && (cur_y == Y_LAST);
        emit     = accept && (cur_x >= X_W'(2)) && (cur_y >= Y_W'(2));
        if (accept) begin
            if (cur_x == X_LAST) begin
                x_d = '0;
                y_d = cur_y + 1'b1;
            end else begin
                x_d = cur_x + 1'b1;
                y_d = cur_y;
            end
            state_d = last_pix ? DONE : ACTIVE;
        end
    end

    line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W), .AW(LB_AW)) u_lb0 (
        .clk   (clk),
        .en    (accept),
        .addr  (cur_x[LB_AW-1:0]),
        .wdata (pix_data),
        .rdata (lb0_rdata)
    );

    // LB1 trails LB0 by one cycle so it can take LB0's evicted row directly
    line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W), .AW(LB_AW)) u_lb1 (
        .clk   (clk),
        .en    (s1_q.acc),
        .addr  (s1_q.col[LB_AW-1:0]),
        .wdata (lb0_rdata),
        .rdata (lb1_rdata)
    );

    always_comb begin
        s1_d         = '{acc: accept, emit: emit, last: last_pix,
                         col: cur_x, row: cur_y, pix: pix_data};
        s2_d         = s1_q;
        mid_d        = lb0_rdata;
        new_col      = '{u: lb1_rdata, m: mid_q, d: s2_q.pix};
        col_l_d      = col_l_q;
        col_m_d      = col_m_q;
        win_d        = win_q;
        win_x_d      = win_x_q;
        win_y_d      = win_y_q;
        win_valid_d  = s2_q.emit;
        frame_done_d = s2_q.emit && s2_q.last;
        if (s2_q.acc) begin
            col_l_d = col_m_q;
            col_m_d = new_col;
        end
        if (s2_q.emit) begin
            win_d   = '{lu: col_l_q.u, lm: col_l_q.m, ld: col_l_q.d,
                        mu: col_m_q.u, mm: col_m_q.m, md: col_m_q.d,
                        ru: new_col.u, rm: new_col.m, rd: new_col.d};
            win_x_d = s2_q.col - 1'b1;
            win_y_d = s2_q.row - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            s1_q         <= '0;
            s2_q         <= '0;
            mid_q        <= '0;
            col_l_q      <= '0;
            col_m_q      <= '0;
            win_q        <= '0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            mid_q        <= mid_d;
            col_l_q      <= col_l_d;
            col_m_q      <= col_m_d;
            win_q        <= win_d;
            win_x_q      <= win_x_d;
            win_y_q      <= win_y_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
    assign win_x      = win_x_q;
    assign win_y      = win_y_q;
    assign win_lu     = win_q.lu;
    assign win_lm     = win_q.lm;
    assign win_ld     = win_q.ld;
    assign win_mu     = win_q.mu;
    assign win_mm     = win_q.mm;
    assign win_md     = win_q.md;
    assign win_ru     = win_q.ru;
    assign win_rm     = win_q.rm;
    assign win_rd     = win_q.rd;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on an 8x6 image: a scoreboard of expected
// windows built from the pixel formula, plus a table of hand-computed windows.
module tb_sobel_window_gen;

    localparam int W   = 8;
    localparam int H   = 6;
    localparam int X_W = 9;
    localparam int Y_W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           pix_valid;
    logic [11:0]    pix_data;
    logic           frame_start;
    logic           win_valid;
    logic [11:0]    win_lu, win_lm, win_ld, win_mu, win_mm, win_md, win_ru, win_rm, win_rd;
    logic [X_W-1:0] win_x;
    logic [Y_W-1:0] win_y;
    logic           frame_done;

    sobel_window_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .X_W        (X_W),
        .Y_W        (Y_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .frame_start (frame_start),
        .win_valid   (win_valid),
        .win_lu      (win_lu),
        .win_lm      (win_lm),
        .win_ld      (win_ld),
        .win_mu      (win_mu),
        .win_mm      (win_mm),
        .win_md      (win_md),
        .win_ru      (win_ru),
        .win_rm      (win_rm),
        .win_rd      (win_rd),
        .win_x       (win_x),
        .win_y       (win_y),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        int           edge_no;
        int           cx;
        int           cy;
        logic         done;
        logic [107:0] w;
    } win_rec_t;

    typedef struct {
        int          cx;
        int          cy;
        logic [11:0] lu;
        logic [11:0] mm;
        logic [11:0] rd;
    } vec_t;

    win_rec_t exp_q[$];
    win_rec_t log_q[$];
    bit       log_en = 1'b0;

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [11:0] pv(input int x, input int y, input int off);
        logic [3:0]  xx;
        logic [3:0]  yy;
        logic [11:0] o;
        xx = x[3:0];
        yy = y[3:0];
        o  = off[11:0];
        return {yy, xx, 4'h0} + o;
    endfunction

    // Order lu,lm,ld,mu,mm,md,ru,rm,rd: column x-1/x/x+1, row y-1/y/y+1
    function automatic logic [107:0] exp_window(input int cx, input int cy, input int off);
        return {pv(cx-1, cy-1, off), pv(cx-1, cy, off), pv(cx-1, cy+1, off),
                pv(cx,   cy-1, off), pv(cx,   cy, off), pv(cx,   cy+1, off),
                pv(cx+1, cy-1, off), pv(cx+1, cy, off), pv(cx+1, cy+1, off)};
    endfunction

    // Drives one pixel for one edge; when the DUT should accept it and it
    // completes a window, the window is expected 2 edges after acceptance.
    task automatic apply_stimulus(input bit fs, input int x, input int y, input int off, input bit active);
        win_rec_t e;
        pix_valid   = 1'b1;
        frame_start = fs;
        pix_data    = pv(x, y, off);
        if (active && x >= 2 && y >= 2) begin
            e.edge_no = edge_cnt + 3;
            e.cx      = x - 1;
            e.cy      = y - 1;
            e.done    = (x == W-1) && (y == H-1);
            e.w       = exp_window(x - 1, y - 1, off);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        pix_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int off, input int gap_pct, input int stop_idx);
        for (int idx = 0; idx < stop_idx; idx++) begin
            if (gap_pct > 0) begin
                while ($urandom_range(0, 99) < gap_pct) idle(1);
            end
            apply_stimulus(idx == 0, idx % W, idx / W, off, 1'b1);
        end
    endtask

    task automatic drain(input string name);
        idle(6);
        check_output(name, exp_q.size(), 0);
    endtask

    task automatic check_cleared(input string tag);
        check_output({tag, "_win_valid"},  win_valid, 1'b0);
        check_output({tag, "_frame_done"}, frame_done, 1'b0);
        check_output({tag, "_window"},
                     {win_lu, win_lm, win_ld, win_mu, win_mm, win_md, win_ru, win_rm, win_rd}, 108'd0);
        check_output({tag, "_win_x"}, win_x, 0);
        check_output({tag, "_win_y"}, win_y, 0);
    endtask

    // Scoreboard: every valid window must match the head of the expected queue
    always @(negedge clk) begin : monitor
        win_rec_t e;
        win_rec_t a;
        if (win_valid === 1'b1) begin
            a.edge_no = edge_cnt;
            a.cx      = int'(win_x);
            a.cy      = int'(win_y);
            a.done    = frame_done;
            a.w       = {win_lu, win_lm, win_ld, win_mu, win_mm, win_md, win_ru, win_rm, win_rd};
            if (log_en) log_q.push_back(a);
            if (exp_q.size() == 0) begin
                check_output("unexpected_window", win_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check_output("win_latency_edge", a.edge_no, e.edge_no);
                check_output("win_x",  a.cx, e.cx);
                check_output("win_y",  a.cy, e.cy);
                check_output("window", a.w, e.w);
                check_output("frame_done", a.done, e.done);
            end
        end else if (frame_done === 1'b1) begin
            check_output("stray_frame_done", frame_done, 1'b0);
        end
    end

    initial begin
        vec_t vecs[4];
        bit   found;

        vecs[0] = '{cx: 1, cy: 1, lu: 12'h000, mm: 12'h110, rd: 12'h220};
        vecs[1] = '{cx: 3, cy: 2, lu: 12'h120, mm: 12'h230, rd: 12'h340};
        vecs[2] = '{cx: 6, cy: 4, lu: 12'h350, mm: 12'h460, rd: 12'h570};
        vecs[3] = '{cx: 1, cy: 4, lu: 12'h300, mm: 12'h410, rd: 12'h520};

        rst         = 1'b1;
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        pix_data    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_cleared("reset");

        $display("[TB] pixels before any frame_start, then a clean frame");
        for (int i = 0; i < 20; i++) apply_stimulus(1'b0, i % W, i / W, 'h3, 1'b0);
        drain("pre_frame_pending");
        send_frame(0, 0, W*H);
        drain("clean_frame_pending");

        $display("[TB] full frame, continuous pixels");
        log_q.delete();
        log_en = 1'b1;
        send_frame(0, 0, W*H);
        drain("full_frame_pending");
        log_en = 1'b0;
        check_output("full_frame_windows", log_q.size(), (W-2)*(H-2));
        if (log_q.size() == (W-2)*(H-2)) begin
            check_output("first_centre", {log_q[0].cx, log_q[0].cy}, {32'd1, 32'd1});
            check_output("last_centre",  {log_q[23].cx, log_q[23].cy}, {32'd6, 32'd4});
        end
        for (int v = 0; v < 4; v++) begin
            found = 1'b0;
            foreach (log_q[k]) begin
                if (!found && log_q[k].cx == vecs[v].cx && log_q[k].cy == vecs[v].cy) begin
                    found = 1'b1;
                    check_output("tbl_lu", log_q[k].w[107:96], vecs[v].lu);
                    check_output("tbl_mm", log_q[k].w[59:48],  vecs[v].mm);
                    check_output("tbl_rd", log_q[k].w[11:0],   vecs[v].rd);
                end
            end
            check_output("tbl_found", found, 1'b1);
        end

        $display("[TB] extra pixels after the last pixel");
        for (int i = 0; i < 10; i++) apply_stimulus(1'b0, i % W, i / W, 0, 1'b0);
        drain("after_done_pending");

        $display("[TB] random gaps on pix_valid");
        send_frame(0, 50, W*H);
        drain("gap_frame_pending");

        $display("[TB] frame_start mid-frame at pixel (3,4)");
        send_frame(0, 0, 4*W + 3);
        send_frame('h008, 0, W*H);
        drain("restart_pending");

        $display("[TB] reset at pixel (5,3)");
        send_frame(0, 0, 3*W + 5);
        pix_valid = 1'b1;
        pix_data  = pv(5, 3, 0);
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        pix_valid = 1'b0;
        exp_q.delete();
        check_cleared("mid_reset");
        for (int idx = 3*W + 6; idx < W*H; idx++) apply_stimulus(1'b0, idx % W, idx / W, 0, 1'b0);
        drain("post_reset_pending");
        send_frame('h004, 25, W*H);
        drain("recovery_pending");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
